// File: rtl/shift_seq_pkg.sv
// ============================================================================
// shift_seq_pkg : shared types and constants for the sequential shifter
// Revision: 1.0
// ============================================================================
`default_nettype none

package shift_seq_pkg;

  localparam int DATA_W = 16;

  localparam logic [3:0] W0 = 4'd1;
  localparam logic [3:0] W1 = 4'd3;
  localparam logic [3:0] W2 = 4'd9;

  localparam logic [1:0] OP_SLL  = 2'b00;
  localparam logic [1:0] OP_SRA  = 2'b01;
  localparam logic [1:0] OP_ROR  = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_L0   = 3'd1,
    ST_L1   = 3'd2,
    ST_L2   = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  typedef struct packed {
    logic       d2;
    logic [1:0] d1;
    logic [1:0] d0;
  } digits_t;

  // Base-3 split of the amount; the reserved op collapses to a no-op shift.
  function automatic digits_t decode_digits(input logic [3:0] shamt, input logic [1:0] op);
    digits_t d;
    d = '0;
    if (op != OP_RSVD) begin
      d.d0 = 2'(shamt % 4'd3);
      d.d1 = 2'((shamt / 4'd3) % 4'd3);
      d.d2 = (shamt >= 4'd9);
    end
    return d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/shift_sequencer_if.sv
// ============================================================================
// shift_sequencer_if : request/response handshake bundle for shift_sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

interface shift_sequencer_if;

  logic                              req_valid;
  logic                              req_ready;
  logic [shift_seq_pkg::DATA_W-1:0]  req_data;
  logic [3:0]                        req_shamt;
  logic [1:0]                        req_op;
  logic                              resp_valid;
  logic                              resp_ready;
  logic [shift_seq_pkg::DATA_W-1:0]  resp_data;

  modport master (
    output req_valid, req_data, req_shamt, req_op, resp_ready,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_data, req_shamt, req_op, resp_ready,
    output req_ready, resp_valid, resp_data
  );

endinterface

`default_nettype wire

// File: rtl/shift_seq_level.sv
// ============================================================================
// shift_seq_level : one combinational shift level (SLL / SRA / ROR / pass)
// Revision: 1.0
// ============================================================================
`default_nettype none

module shift_seq_level
  import shift_seq_pkg::*;
(
  input  logic [DATA_W-1:0] data_i,
  input  logic [1:0]        op_i,
  input  logic [3:0]        amt_i,
  output logic [DATA_W-1:0] data_o
);

  logic [2*DATA_W-1:0] w_rot;
  logic [DATA_W-1:0]   w_sll;
  logic [DATA_W-1:0]   w_sra;

  assign w_rot = {data_i, data_i} >> amt_i;
  assign w_sll = data_i << amt_i;
  assign w_sra = DATA_W'($signed(data_i) >>> amt_i);

  always_comb begin
    data_o = data_i;
    case (op_i)
      OP_SLL:  data_o = w_sll;
      OP_SRA:  data_o = w_sra;
      OP_ROR:  data_o = w_rot[DATA_W-1:0];
      default: data_o = data_i;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/shift_sequencer.sv
// ============================================================================
// shift_sequencer : multi-cycle 16-bit shifter, one base-3 level per cycle.
// Build option: SHIFT_SEQ_SKIP_ZERO_EN skips levels whose digit is zero.
// Revision: 1.0
// ============================================================================
`default_nettype none

module shift_sequencer
  import shift_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  shift_sequencer_if.slave  bus,
  output logic              busy
);

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  work_q;
  logic [1:0]         op_q;
  digits_t            dig_q;

  digits_t            w_acc_dig;
  logic               w_accept;
  logic [3:0]         w_amt;
  logic [DATA_W-1:0]  w_level;
  state_e             w_start;
  state_e             w_after_l0;
  state_e             w_after_l1;

  assign w_acc_dig = decode_digits(bus.req_shamt, bus.req_op);
  assign w_accept  = bus.req_valid & bus.req_ready;

`ifdef SHIFT_SEQ_SKIP_ZERO_EN
  function automatic state_e next_level(input digits_t d, input logic [1:0] from);
    if ((from == 2'd0) && (d.d0 != 2'd0)) return ST_L0;
    if ((from <= 2'd1) && (d.d1 != 2'd0)) return ST_L1;
    if (d.d2) return ST_L2;
    return ST_DONE;
  endfunction

  assign w_start    = next_level(w_acc_dig, 2'd0);
  assign w_after_l0 = next_level(dig_q, 2'd1);
  assign w_after_l1 = next_level(dig_q, 2'd2);
`else
  assign w_start    = ST_L0;
  assign w_after_l0 = ST_L1;
  assign w_after_l1 = ST_L2;
`endif

  // Weighted amount for the level currently being applied.
  always_comb begin
    w_amt = 4'd0;
    case (state_q)
      ST_L0:   w_amt = {2'b00, dig_q.d0} * W0;
      ST_L1:   w_amt = {2'b00, dig_q.d1} * W1;
      ST_L2:   w_amt = dig_q.d2 ? W2 : 4'd0;
      default: w_amt = 4'd0;
    endcase
  end

  shift_seq_level u_level (
    .data_i (work_q),
    .op_i   (op_q),
    .amt_i  (w_amt),
    .data_o (w_level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.req_valid) state_d = w_start;
      ST_L0:   state_d = w_after_l0;
      ST_L1:   state_d = w_after_l1;
      ST_L2:   state_d = ST_DONE;
      ST_DONE: if (bus.resp_ready) state_d = bus.req_valid ? w_start : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready  = (state_q == ST_IDLE) | ((state_q == ST_DONE) & bus.resp_ready);
    bus.resp_valid = (state_q == ST_DONE);
    bus.resp_data  = work_q;
    busy           = (state_q != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_q <= '0;
      op_q   <= '0;
      dig_q  <= '0;
    end else if (w_accept) begin
      work_q <= bus.req_data;
      op_q   <= bus.req_op;
      dig_q  <= w_acc_dig;
    end else if ((state_q == ST_L0) || (state_q == ST_L1) || (state_q == ST_L2)) begin
      work_q <= w_level;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_shift_sequencer.sv
// ============================================================================
// tb_shift_sequencer : directed vector bench for shift_sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_shift_sequencer;

  logic clk;
  logic rst_n;
  logic busy;

  shift_sequencer_if bus ();

  shift_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] data;
    logic [3:0]  shamt;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [1:0] op, input logic [3:0] shamt);
`ifdef SHIFT_SEQ_SKIP_ZERO_EN
    int n;
    if (op == 2'b11) return 0;
    n = 0;
    if (shamt % 3 != 0) n++;
    if ((shamt / 3) % 3 != 0) n++;
    if (shamt >= 9) n++;
    return n;
`else
    return 3;
`endif
  endfunction

  task automatic send(input logic [1:0] op, input logic [15:0] data, input logic [3:0] shamt);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_data  = data;
    bus.req_shamt = shamt;
    chk("req_ready_before_accept", {31'd0, bus.req_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  // Call #1 after the accept edge; counts edges until resp_valid shows.
  task automatic wait_valid(input int exp_l);
    int n;
    n = 0;
    while (!bus.resp_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!bus.resp_valid) begin
      checks++;
      errors++;
      $display("FAIL resp_valid_timeout: got 0 expected 1 within 20 cycles");
    end
    chk("latency", n, exp_l);
  endtask

  task automatic release_resp();
    @(negedge clk);
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
    chk("resp_valid_after_release", {31'd0, bus.resp_valid}, 32'd0);
    chk("busy_after_release", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{2'b00, 16'h0001, 4'd15, 16'h8000};
    vecs[1]  = '{2'b01, 16'h8000, 4'd4,  16'hF800};
    vecs[2]  = '{2'b01, 16'h4000, 4'd14, 16'h0001};
    vecs[3]  = '{2'b10, 16'h1234, 4'd4,  16'h4123};
    vecs[4]  = '{2'b10, 16'hABCD, 4'd0,  16'hABCD};
    vecs[5]  = '{2'b11, 16'h5A5A, 4'd7,  16'h5A5A};
    vecs[6]  = '{2'b00, 16'hFFFF, 4'd9,  16'hFE00};
    vecs[7]  = '{2'b10, 16'h8001, 4'd9,  16'h00C0};
    vecs[8]  = '{2'b01, 16'h7FFF, 4'd15, 16'h0000};
    vecs[9]  = '{2'b01, 16'hFFFF, 4'd1,  16'hFFFF};
    vecs[10] = '{2'b00, 16'h1234, 4'd8,  16'h3400};
    vecs[11] = '{2'b10, 16'h0F00, 4'd12, 16'hF000};

    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_data   = '0;
    bus.req_shamt  = '0;
    bus.req_op     = '0;
    bus.resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("reset_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("reset_resp_data", {16'd0, bus.resp_data}, 32'h0000);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      send(vecs[i].op, vecs[i].data, vecs[i].shamt);
      // Requests offered while busy must be ignored.
      bus.req_valid = 1'b1;
      bus.req_data  = 16'hDEAD;
      bus.req_shamt = 4'd3;
      bus.req_op    = 2'b00;
      wait_valid(exp_lat(vecs[i].op, vecs[i].shamt));
      chk($sformatf("vec%0d_resp_data", i), {16'd0, bus.resp_data}, {16'd0, vecs[i].exp});
      chk($sformatf("vec%0d_busy", i), {31'd0, busy}, 32'd1);
      release_resp();
    end

    // Back-pressure in DONE, then a same-cycle response/request handoff.
    send(2'b01, 16'h8000, 4'd4);
    wait_valid(exp_lat(2'b01, 4'd4));
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk("stall_resp_valid", {31'd0, bus.resp_valid}, 32'd1);
      chk("stall_resp_data", {16'd0, bus.resp_data}, 32'hF800);
      chk("stall_req_ready", {31'd0, bus.req_ready}, 32'd0);
    end
    @(negedge clk);
    bus.resp_ready = 1'b1;
    bus.req_valid  = 1'b1;
    bus.req_op     = 2'b00;
    bus.req_data   = 16'h0003;
    bus.req_shamt  = 4'd1;
    #1;
    chk("handoff_req_ready", {31'd0, bus.req_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b0;
    chk("handoff_resp_valid_dropped", {31'd0, bus.resp_valid}, 32'd0);
    chk("handoff_busy", {31'd0, busy}, 32'd1);
    wait_valid(exp_lat(2'b00, 4'd1));
    chk("handoff_resp_data", {16'd0, bus.resp_data}, 32'h0006);
    release_resp();

    // Asynchronous reset while the second level is in progress.
    send(2'b00, 16'h00FF, 4'd13);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("midreset_resp_data", {16'd0, bus.resp_data}, 32'h0000);
    chk("midreset_busy", {31'd0, busy}, 32'd0);
    chk("midreset_req_ready", {31'd0, bus.req_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    send(2'b00, 16'h00FF, 4'd13);
    wait_valid(exp_lat(2'b00, 4'd13));
    chk("postreset_resp_data", {16'd0, bus.resp_data}, 32'hE000);
    release_resp();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
